// File: rtl/muldiv_module.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_module
//  Description : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_module #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH:0]   opnd_q, opnd_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dbz_out_q, dbz_out_d;

   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH+1:0]   w_add, w_msum, w_diff;
   logic [WIDTH:0]     w_shift;
   logic               w_borrow;
   logic [WIDTH:0]     w_acc_nx;
   logic [WIDTH-1:0]   w_mq_nx;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;
   logic [WIDTH-1:0]   w_quo, w_rem;

   assign busy        = (state_q == S_CALC);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_out_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

   // Signed ops work on magnitudes; most-negative maps to 2^(WIDTH-1) unsigned.
   always_comb begin
      w_a_neg = ~op[0] & A[WIDTH-1];
      w_b_neg = ~op[0] & B[WIDTH-1];
      w_a_mag = w_a_neg ? (~A + 1'b1) : A;
      w_b_mag = w_b_neg ? (~B + 1'b1) : B;
   end

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      w_add    = {1'b0, acc_q} + {1'b0, opnd_q};
      w_msum   = mq_q[0] ? w_add : {1'b0, acc_q};
      w_shift  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
      w_diff   = {1'b0, w_shift} - {1'b0, opnd_q};
      w_borrow = w_diff[WIDTH+1];
      if (is_div_q) begin
         w_acc_nx = w_borrow ? w_shift : w_diff[WIDTH:0];
         w_mq_nx  = {mq_q[WIDTH-2:0], ~w_borrow};
      end else begin
         w_acc_nx = w_msum[WIDTH+1:1];
         w_mq_nx  = {w_msum[0], mq_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      w_prod   = {w_acc_nx[WIDTH-1:0], w_mq_nx};
      w_prod_s = neg_res_q ? (~w_prod + 1'b1) : w_prod;
      w_quo    = neg_res_q ? (~w_mq_nx + 1'b1) : w_mq_nx;
      w_rem    = neg_rem_q ? (~w_acc_nx[WIDTH-1:0] + 1'b1) : w_acc_nx[WIDTH-1:0];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_out_d = dbz_out_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_CALC;
               cnt_d     = '0;
               acc_d     = '0;
               is_div_d  = op[1];
               neg_res_d = w_a_neg ^ w_b_neg;
               neg_rem_d = w_a_neg;
               dbz_d     = op[1] & (B == '0);
               opnd_d    = op[1] ? {1'b0, w_b_mag} : {1'b0, w_a_mag};
               mq_d      = op[1] ? w_a_mag : w_b_mag;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            acc_d = w_acc_nx;
            mq_d  = w_mq_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d   = S_DONE;
               dbz_out_d = dbz_q;
               if (is_div_q) begin
                  // Divide-by-zero leaves remainder = |A| re-signed, i.e. A itself.
                  hi_d = w_rem;
                  lo_d = dbz_q ? '1 : w_quo;
               end else begin
                  hi_d = w_prod_s[2*WIDTH-1:WIDTH];
                  lo_d = w_prod_s[WIDTH-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_out_q <= dbz_out_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_module
//  Description : Scoreboard bench for muldiv_module against an arithmetic model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_module;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   logic [64:0] exp_q[$];
   logic [64:0] e;

   muldiv_module #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // {div_by_zero, hi, lo} from plain integer arithmetic.
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa, sb, q, r;
      sa = a;
      sb = b;
      if (o == 2'd0) begin
         sp = longint'(sa) * longint'(sb);
         up = sp;
         return {1'b0, up};
      end else if (o == 2'd1) begin
         up = {32'h0, a} * {32'h0, b};
         return {1'b0, up};
      end else if (b == 32'h0) begin
         return {1'b1, a, 32'hFFFF_FFFF};
      end else if (o == 2'd3) begin
         return {1'b0, a % b, a / b};
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         return {1'b0, 32'h0, 32'h8000_0000};
      end else begin
         q = sa / sb;
         r = sa % sb;
         return {1'b0, r, q};
      end
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            e = exp_q.pop_front();
            chk("hi", hi, e[63:32]);
            chk("lo", lo, e[31:0]);
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e[64]});
         end
      end
   end

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit mid_start);
      int lat, bc;
      lat = 0;
      bc  = 0;
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      exp_q.push_back(model(o, a, b));
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            op = 2'($urandom);
            A = $urandom;
            B = $urandom;
         end
         if (mid_start && k == 5) start = 1'b1;
         if (mid_start && k == 6) start = 1'b0;
         if (busy) bc++;
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      chk("latency", lat, 33);
      chk("busy_cycles", bc, 32);
   endtask

   function automatic logic [31:0] pick(input bit zero_bias);
      int s;
      s = $urandom_range(0, 9);
      if (s == 0 || (zero_bias && s == 1)) return 32'h0;
      if (s == 2) return 32'h8000_0000;
      if (s == 3) return 32'hFFFF_FFFF;
      if (s == 4) return 32'($urandom_range(0, 20));
      return $urandom;
   endfunction

   initial begin
      int t0, d1, d2;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'h0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      rst = 1'b0;

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(2'd3, 32'd100, 32'd7, 1'b0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
      run_op(2'd3, 32'h1234, 32'h0, 1'b0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'h0, 1'b0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

      // Reset mid-operation: abort, clear results, and no done afterwards.
      @(negedge clk);
      op = 2'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_rst_busy", {31'b0, busy}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", {31'b0, busy}, 32'h0);
      chk("post_rst_done", {31'b0, done}, 32'h0);
      chk("post_rst_hi", hi, 32'h0);
      chk("post_rst_lo", lo, 32'h0);
      rst = 1'b0;
      t0 = done_cnt;
      repeat (40) @(negedge clk);
      chk("no_done_after_rst", done_cnt - t0, 0);

      // Back-to-back: start held across DONE, operands changed after acceptance.
      t0 = done_cnt; d1 = 0; d2 = 0;
      @(negedge clk);
      op = 2'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
      exp_q.push_back(model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 1) begin
            op = 2'd2; A = 32'hFFFF_FFF9; B = 32'd2;
            exp_q.push_back(model(2'd2, 32'hFFFF_FFF9, 32'd2));
         end
         if (done && d1 == 0) d1 = k;
         else if (done) d2 = k;
         if (d1 != 0 && k == d1 + 1) begin
            start = 1'b0;
            chk("b2b_done_drop", {31'b0, done}, 32'h0);
            chk("b2b_busy_rise", {31'b0, busy}, 32'h1);
         end
      end
      start = 1'b0;
      chk("b2b_first_done", d1, 33);
      chk("b2b_spacing", d2 - d1, 33);
      chk("b2b_done_count", done_cnt - t0, 2);

      for (int i = 0; i < 30; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         o = 2'($urandom_range(0, 3));
         a = pick(1'b0);
         b = pick(1'b1);
         run_op(o, a, b, (i % 7) == 3);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
